// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: bus widths, stall encoding, load opcodes, FSM states.
package mem_stage_pkg;

    localparam int unsigned EX_TO_MEM_WD = 82;
    localparam int unsigned MEM_TO_WB_WD = 70;
    localparam int unsigned MEM_TO_ID_WD = 38;
    localparam int unsigned StallBus     = 6;

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    localparam logic [5:0] LdLb  = 6'b100000;
    localparam logic [5:0] LdLbu = 6'b100100;
    localparam logic [5:0] LdLh  = 6'b100001;
    localparam logic [5:0] LdLhu = 6'b100101;
    localparam logic [5:0] LdLw  = 6'b100011;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StHold
    } mem_state_e;

    // True when ld_type names one of the five load flavours.
    function automatic logic is_ld_code(input logic [5:0] ld_type);
        return (ld_type == LdLb) || (ld_type == LdLbu) || (ld_type == LdLh) ||
               (ld_type == LdLhu) || (ld_type == LdLw);
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment and sign/zero extension, plus misalignment detection.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [5:0]  ld_type_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] data_o,
    output logic        misalign_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte/half and extend according to the load flavour.
    always_comb begin
        byte_sel = rdata_i[7:0];
        case (addr_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        data_o     = rdata_i;
        misalign_o = 1'b0;
        case (ld_type_i)
            LdLb:  data_o = {{24{byte_sel[7]}}, byte_sel};
            LdLbu: data_o = {24'h0, byte_sel};
            LdLh: begin
                data_o     = {{16{half_sel[15]}}, half_sel};
                misalign_o = addr_i[0];
            end
            LdLhu: begin
                data_o     = {16'h0, half_sel};
                misalign_o = addr_i[0];
            end
            LdLw: begin
                data_o     = rdata_i;
                misalign_o = (addr_i != 2'd0);
            end
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: registers the execute bus, waits for load data, aligns it and
// drives the writeback and forwarding buses.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [StallBus-1:0]     stall,
    input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    input  logic [31:0]             data_sram_rdata,
    input  logic                    data_sram_rvalid,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic [MEM_TO_ID_WD-1:0] mem_to_id_bus,
    output logic                    stall_mem,
    output logic                    mem_misalign,
    output logic                    mem_timeout
);

    localparam int unsigned CntW = $clog2(WAIT_LIMIT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(WAIT_LIMIT - 1);

    logic [EX_TO_MEM_WD-1:0] ex_q;
    mem_state_e              state_q;
    logic [31:0]             buf_q;
    logic [CntW-1:0]         cnt_q;
    logic                    timeout_q;

    logic [5:0]  ld_type;
    logic [31:0] pc;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
    logic        is_load;
    logic        ld_ok;
    logic        reg_hold;
    logic [31:0] aligned;
    logic        misalign;
    logic [31:0] rf_wdata;
    logic        rf_we_out;
    logic        unused_bits;

    assign ld_type   = ex_q[81:76];
    assign pc        = ex_q[75:44];
    assign ram_en    = ex_q[43];
    assign ram_wen   = ex_q[42:39];
    assign rf_we     = ex_q[37];
    assign rf_waddr  = ex_q[36:32];
    assign ex_result = ex_q[31:0];

    assign unused_bits = ^{ex_q[38], stall[2:0], stall[5]};

    assign is_load  = ram_en && (ram_wen == 4'b0000) && is_ld_code(ld_type);
    assign ld_ok    = is_load && !misalign;
    assign reg_hold = (stall[3] == Stop) && (stall[4] == Stop);

    load_align u_load_align (
        .ld_type_i  (ld_type),
        .addr_i     (ex_result[1:0]),
        .rdata_i    (data_sram_rdata),
        .data_o     (aligned),
        .misalign_o (misalign)
    );

    // Input register: bubble when this stage stops but writeback proceeds, load when free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q <= '0;
        end else if ((stall[3] == Stop) && (stall[4] == NoStop)) begin
            ex_q <= '0;
        end else if (stall[3] == NoStop) begin
            ex_q <= ex_to_mem_bus;
        end
    end

    // Load-wait FSM with data buffer, wait counter and sticky timeout flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            buf_q     <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (ld_ok) begin
                        if (!data_sram_rvalid) begin
                            state_q <= StWait;
                            cnt_q   <= '0;
                        end else if (reg_hold) begin
                            // Same-cycle data but the load stays put: keep it for later cycles.
                            buf_q   <= aligned;
                            state_q <= StHold;
                        end
                    end
                end
                StWait: begin
                    if (data_sram_rvalid) begin
                        buf_q   <= aligned;
                        cnt_q   <= '0;
                        state_q <= StHold;
                    end else if (cnt_q == CntLast) begin
                        timeout_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StHold: begin
                    if (!reg_hold) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Writeback data selection and output bus assembly.
    always_comb begin
        rf_wdata = ex_result;
        if (is_load) begin
            rf_wdata = (state_q == StHold) ? buf_q : aligned;
        end
        rf_we_out    = rf_we && !(is_load && misalign);
        mem_misalign = is_load && misalign;
        stall_mem    = (state_q == StWait) ||
                       ((state_q == StIdle) && ld_ok && !data_sram_rvalid);
        mem_to_wb_bus = {pc, rf_we_out, rf_waddr, rf_wdata};
        mem_to_id_bus = {rf_we_out && !stall_mem, rf_waddr, rf_wdata};
        mem_timeout   = timeout_q;
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic [81:0] ex_bus;
    logic [31:0] rdata;
    logic        rvalid;
    logic [69:0] wb_bus;
    logic [37:0] id_bus;
    logic        stall_mem;
    logic        misalign;
    logic        timeout;

    int compared   = 0;
    int mismatched = 0;

    mem_stage dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .ex_to_mem_bus    (ex_bus),
        .data_sram_rdata  (rdata),
        .data_sram_rvalid (rvalid),
        .mem_to_wb_bus    (wb_bus),
        .mem_to_id_bus    (id_bus),
        .stall_mem        (stall_mem),
        .mem_misalign     (misalign),
        .mem_timeout      (timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [81:0] mk(input logic [5:0] lt, input logic [31:0] pc,
                                       input logic en, input logic [3:0] wen, input logic we,
                                       input logic [4:0] wa, input logic [31:0] res);
        return {lt, pc, en, wen, en & ~|wen, we, wa, res};
    endfunction

    function automatic logic [69:0] wbv(input logic [31:0] pc, input logic we,
                                        input logic [4:0] wa, input logic [31:0] wd);
        return {pc, we, wa, wd};
    endfunction

    function automatic logic [37:0] idv(input logic en, input logic [4:0] wa,
                                        input logic [31:0] wd);
        return {en, wa, wd};
    endfunction

    task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst    = 1'b0;
        stall  = 6'b0;
        ex_bus = '0;
        rdata  = '0;
        rvalid = 1'b0;
        #12;
        chk("rst_wb", wb_bus, 70'h0);
        chk("rst_id", 70'(id_bus), 70'h0);
        chk("rst_stall", 70'(stall_mem), 70'h0);
        chk("rst_misalign", 70'(misalign), 70'h0);
        chk("rst_timeout", 70'(timeout), 70'h0);
        chk("rst_state", 70'(dut.state_q), 70'(StIdle));
        rst = 1'b1;

        // LW at 0x100 with same-cycle data
        ex_bus = mk(LdLw, 32'h1000, 1'b1, 4'h0, 1'b1, 5'd5, 32'h100);
        tick();
        rdata  = 32'h8899AABB;
        rvalid = 1'b1;
        #1;
        chk("lw_wb", wb_bus, wbv(32'h1000, 1'b1, 5'd5, 32'h8899AABB));
        chk("lw_id", 70'(id_bus), 70'(idv(1'b1, 5'd5, 32'h8899AABB)));
        chk("lw_stall", 70'(stall_mem), 70'h0);

        // Byte/half loads against 0x80FF0011
        ex_bus = mk(LdLb, 32'h1004, 1'b1, 4'h0, 1'b1, 5'd6, 32'h103);
        tick();
        rdata = 32'h80FF0011;
        #1;
        chk("lb_data", 70'(wb_bus[31:0]), 70'(32'hFFFFFF80));
        ex_bus = mk(LdLbu, 32'h1008, 1'b1, 4'h0, 1'b1, 5'd6, 32'h103);
        tick();
        chk("lbu_data", 70'(wb_bus[31:0]), 70'(32'h00000080));
        ex_bus = mk(LdLh, 32'h100C, 1'b1, 4'h0, 1'b1, 5'd6, 32'h102);
        tick();
        chk("lh_data", 70'(wb_bus[31:0]), 70'(32'hFFFF80FF));

        // LW at 0x200 with data three cycles late
        rvalid = 1'b0;
        ex_bus = mk(LdLw, 32'h2000, 1'b1, 4'h0, 1'b1, 5'd7, 32'h200);
        tick();
        chk("dly_stall1", 70'(stall_mem), 70'h1);
        chk("dly_en1", 70'(id_bus[37]), 70'h0);
        stall = 6'b011111;
        tick();
        chk("dly_stall2", 70'(stall_mem), 70'h1);
        chk("dly_en2", 70'(id_bus[37]), 70'h0);
        tick();
        chk("dly_stall3", 70'(stall_mem), 70'h1);
        chk("dly_en3", 70'(id_bus[37]), 70'h0);
        rdata  = 32'h12345678;
        rvalid = 1'b1;
        tick();
        chk("dly_stall4", 70'(stall_mem), 70'h0);
        chk("dly_wb", wb_bus, wbv(32'h2000, 1'b1, 5'd7, 32'h12345678));
        chk("dly_en4", 70'(id_bus[37]), 70'h1);
        chk("dly_hold", 70'(dut.state_q), 70'(StHold));
        rdata  = 32'hDEADBEEF;
        rvalid = 1'b0;
        tick();
        chk("dly_hold2", 70'(dut.state_q), 70'(StHold));
        chk("dly_buf", 70'(wb_bus[31:0]), 70'(32'h12345678));

        // Misaligned LH at 0x001
        stall  = 6'b0;
        ex_bus = mk(LdLh, 32'h2004, 1'b1, 4'h0, 1'b1, 5'd8, 32'h001);
        tick();
        chk("mis_idle", 70'(dut.state_q), 70'(StIdle));
        chk("mis_flag", 70'(misalign), 70'h1);
        chk("mis_wbwe", 70'(wb_bus[37]), 70'h0);
        chk("mis_iden", 70'(id_bus[37]), 70'h0);
        chk("mis_stall", 70'(stall_mem), 70'h0);
        tick();
        chk("mis_stay_idle", 70'(dut.state_q), 70'(StIdle));

        // Store carrying an LW code and misaligned address passes through
        ex_bus = mk(LdLw, 32'h2008, 1'b1, 4'hF, 1'b0, 5'd3, 32'h201);
        tick();
        chk("st_wb", wb_bus, wbv(32'h2008, 1'b0, 5'd3, 32'h201));
        chk("st_misalign", 70'(misalign), 70'h0);
        chk("st_stall", 70'(stall_mem), 70'h0);

        // ADD, then bubble, then hold
        ex_bus = mk(6'h0, 32'h3000, 1'b0, 4'h0, 1'b1, 5'd9, 32'h5);
        tick();
        chk("add_wb", wb_bus, wbv(32'h3000, 1'b1, 5'd9, 32'h5));
        chk("add_id", 70'(id_bus), 70'(idv(1'b1, 5'd9, 32'h5)));
        stall = 6'b001000;
        tick();
        chk("bub_wb", wb_bus, 70'h0);
        chk("bub_id", 70'(id_bus), 70'h0);
        stall = 6'b0;
        tick();
        stall  = 6'b011000;
        ex_bus = mk(6'h0, 32'h3004, 1'b0, 4'h0, 1'b1, 5'd10, 32'h77);
        tick();
        chk("hold_wb", wb_bus, wbv(32'h3000, 1'b1, 5'd9, 32'h5));

        // LW whose data never arrives: timeout after 64 waiting cycles
        stall  = 6'b0;
        rvalid = 1'b0;
        ex_bus = mk(LdLw, 32'h4000, 1'b1, 4'h0, 1'b1, 5'd11, 32'h300);
        tick();
        stall = 6'b011111;
        for (int i = 0; i < 64; i++) tick();
        chk("to_before", 70'(timeout), 70'h0);
        tick();
        chk("to_after", 70'(timeout), 70'h1);
        chk("to_stall", 70'(stall_mem), 70'h1);
        chk("to_wait", 70'(dut.state_q), 70'(StWait));

        // Reset while waiting, then a late rvalid
        #1;
        rst = 1'b0;
        #1;
        chk("rw_stall", 70'(stall_mem), 70'h0);
        chk("rw_timeout", 70'(timeout), 70'h0);
        chk("rw_wb", wb_bus, 70'h0);
        rst    = 1'b1;
        rvalid = 1'b1;
        rdata  = 32'hCAFEF00D;
        tick();
        chk("late_state", 70'(dut.state_q), 70'(StIdle));
        chk("late_wb", wb_bus, 70'h0);
        chk("late_stall", 70'(stall_mem), 70'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
